comparator_nbit_pipe: RTL and testbench
=======================================

COMPARATOR_NBIT_PIPE -- requirements
Module: comparator_nbit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal 2..64).
REQ-002 Parameter STABLE_CNT, default 4, consecutive same-relation samples needed to assert stable (legal 2..255).
REQ-003 Parameter CNT_W, default 16, width of eq_count.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  a/b/cmp_signed sampled this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cmp_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with in_valid.
REQ-011 clr_count  input  1  clear eq_count.
REQ-012 out_valid  output  1  registered flags updated this cycle.
REQ-013 a_gt_b / a_lt_b / a_eq_b  output  1 each  registered relation flags.
REQ-014 stable  output  1  relation unchanged for >= STABLE_CNT consecutive valid samples.
REQ-015 eq_count  output  CNT_W  saturating count of valid equal samples.

Function
REQ-016 Latency exactly 1 cycle: in_valid high at edge N -> out_valid high and flags for that sample visible after edge N+1.
REQ-017 out_valid SHALL be a registered copy of in_valid; back-to-back valids give back-to-back results, no stalls.
REQ-018 When out_valid is high, exactly one of a_gt_b/a_lt_b/a_eq_b SHALL be 1.
REQ-019 When in_valid is low, flags, stable and relation state SHALL hold their previous values; only out_valid drops.
REQ-020 Signed mode: operands interpreted as two's complement of WIDTH bits (e.g. WIDTH=8: 8'hFF < 8'h01); unsigned mode: 8'hFF > 8'h01.
REQ-021 Relation FSM states: IDLE (no sample since reset), TRACK (run length < STABLE_CNT), STABLE.
REQ-022 IDLE -> TRACK on first valid sample; run length := 1.
REQ-023 TRACK: valid sample with same relation as previous -> run+1; reaching STABLE_CNT -> STABLE; different relation -> run := 1, stay TRACK.
REQ-024 STABLE: same relation -> stay (run counter saturates at STABLE_CNT); different relation -> TRACK, run := 1.
REQ-025 stable output SHALL be 1 exactly when FSM is in STABLE, registered, same cycle as the flags of the sample causing entry/exit.
REQ-026 A change of cmp_signed alone does not reset the run; only a change of resulting relation does.
REQ-027 eq_count increments by 1 on each valid sample with a == b (per active mode); saturates at 2^CNT_W-1, no wrap.
REQ-028 clr_count high sets eq_count to 0 next edge; clr_count with a simultaneous valid equal sample yields 0 (clear wins).

Reset
REQ-029 rst high at an edge: out_valid=0, a_gt_b=0, a_lt_b=0, a_eq_b=0, stable=0, eq_count=0, FSM=IDLE, run=0.
REQ-030 rst overrides in_valid and clr_count; a sample presented during reset is discarded.
REQ-031 Reset mid-run: after release, first valid sample re-enters TRACK with run=1 regardless of prior state.

Structure
REQ-032 Shared package comparator_pkg holds the FSM state enum (IDLE/TRACK/STABLE) and relation encoding (GT/LT/EQ).
REQ-033 One sub-module, cmp_core: purely combinational WIDTH-parametrised signed/unsigned relation decode; FSM, counters and output registers live in the top.

Verification
REQ-034 WIDTH=8, unsigned: valid a=150,b=100 -> next cycle out_valid=1, gt=1,lt=0,eq=0; a=60,b=180 -> lt=1; a=200,b=200 -> eq=1, eq_count=1.
REQ-035 WIDTH=8: a=8'hFF,b=8'h01 with cmp_signed=1 -> lt=1; same operands cmp_signed=0 -> gt=1.
REQ-036 STABLE_CNT=4: four valid gt samples (with an idle cycle between 2nd and 3rd) -> stable=1 after 4th; fifth sample lt -> stable=0, lt=1 same cycle.
REQ-037 CNT_W=4: 17 valid equal samples -> eq_count stops at 15; then clr_count with a valid equal sample -> eq_count=0.
REQ-038 rst asserted for one cycle while in STABLE with eq_count=5 -> all outputs 0 next cycle; next valid a=3,b=3 -> eq=1, stable=0, eq_count=1.
REQ-039 WIDTH=32 randomized back-to-back valids vs. reference model: one-hot flags every out_valid cycle, 1-cycle latency throughout.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types for the pipelined comparator: relation FSM states and the
// encoding of the compare result.
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_STABLE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REL_GT = 2'd0,
        REL_LT = 2'd1,
        REL_EQ = 2'd2
    } rel_e;

    localparam int RUN_W = 8;

endpackage

// File: rtl/cmp_core.sv
// Combinational relation decode of two WIDTH-bit operands, either as
// unsigned values or as two's complement.
module cmp_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cmp_signed,
    output rel_e             rel
);

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;

    // One extra bit lets a single signed compare serve both modes.
    assign a_ext = {cmp_signed & a[WIDTH-1], a};
    assign b_ext = {cmp_signed & b[WIDTH-1], b};

    always_comb begin
        rel = REL_EQ;
        if (a_ext > b_ext) begin
            rel = REL_GT;
        end else if (a_ext < b_ext) begin
            rel = REL_LT;
        end
    end

endmodule

// File: rtl/comparator_nbit_pipe.sv
// Registered comparator with relation-stability tracking and a saturating
// count of equal samples.
//
//   state     | meaning
//   ST_IDLE   | no valid sample seen since reset
//   ST_TRACK  | relation run shorter than STABLE_CNT
//   ST_STABLE | relation unchanged for at least STABLE_CNT samples
module comparator_nbit_pipe
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cmp_signed,
    input  logic             clr_count,
    output logic             out_valid,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             stable,
    output logic [CNT_W-1:0] eq_count
);

    localparam logic [RUN_W-1:0] RUN_RELOAD = RUN_W'(STABLE_CNT - 1);

    rel_e             rel_new;
    state_e           state_q, state_d;
    rel_e             rel_q, rel_d;
    logic [RUN_W-1:0] remain_q, remain_d;
    logic             out_valid_q, out_valid_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic [CNT_W-1:0] eq_count_q, eq_count_d;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a          (a),
        .b          (b),
        .cmp_signed (cmp_signed),
        .rel        (rel_new)
    );

    always_comb begin
        state_d     = state_q;
        rel_d       = rel_q;
        remain_d    = remain_q;
        out_valid_d = in_valid;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        eq_count_d  = eq_count_q;

        if (in_valid) begin
            gt_d  = (rel_new == REL_GT);
            lt_d  = (rel_new == REL_LT);
            eq_d  = (rel_new == REL_EQ);
            rel_d = rel_new;

            if (rel_new == REL_EQ && eq_count_q != '1) begin
                eq_count_d = eq_count_q + 1'b1;
            end

            // remain counts down the samples still needed to reach STABLE.
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_TRACK;
                    remain_d = RUN_RELOAD;
                end
                ST_TRACK: begin
                    if (rel_new != rel_q) begin
                        remain_d = RUN_RELOAD;
                    end else if (remain_q == RUN_W'(1)) begin
                        state_d  = ST_STABLE;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (rel_new != rel_q) begin
                        state_d  = ST_TRACK;
                        remain_d = RUN_RELOAD;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                end
            endcase
        end

        if (clr_count) begin
            eq_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rel_q       <= REL_EQ;
            remain_q    <= '0;
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            eq_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rel_q       <= rel_d;
            remain_q    <= remain_d;
            out_valid_q <= out_valid_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            eq_count_q  <= eq_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a_gt_b    = gt_q;
    assign a_lt_b    = lt_q;
    assign a_eq_b    = eq_q;
    assign stable    = (state_q == ST_STABLE);
    assign eq_count  = eq_count_q;

endmodule

// File: tb/tb_comparator_nbit_pipe.sv
// Bench for comparator_nbit_pipe: an 8-bit instance for directed vectors and
// a 32-bit instance for random back-to-back traffic, both against a model.
module tb_comparator_nbit_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v8 = 0, s8 = 0, c8 = 0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ov8, gt8, lt8, eq8, st8;
    logic [3:0]  cnt8;

    logic        v32 = 0, s32 = 0, c32 = 0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ov32, gt32, lt32, eq32, st32;
    logic [15:0] cnt32;

    comparator_nbit_pipe #(.WIDTH(8), .STABLE_CNT(4), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
        .cmp_signed(s8), .clr_count(c8), .out_valid(ov8),
        .a_gt_b(gt8), .a_lt_b(lt8), .a_eq_b(eq8), .stable(st8),
        .eq_count(cnt8)
    );

    comparator_nbit_pipe #(.WIDTH(32), .STABLE_CNT(4), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32),
        .cmp_signed(s32), .clr_count(c32), .out_valid(ov32),
        .a_gt_b(gt32), .a_lt_b(lt32), .a_eq_b(eq32), .stable(st32),
        .eq_count(cnt32)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: relation 1=gt, 2=lt, 3=eq, 0=none.
    bit     m_ov[2], m_gt[2], m_lt[2], m_eq[2], m_st[2];
    longint m_cnt[2];
    int     m_run[2];
    int     m_last[2];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int relation(input longint unsigned a, input longint unsigned b,
                                    input bit s, input int w);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        if (sa > sb) return 1;
        if (sa < sb) return 2;
        return 3;
    endfunction

    task automatic model_step(input int i, input bit v, input longint unsigned a,
                              input longint unsigned b, input bit s, input bit c,
                              input int w, input int n, input int cw);
        int r;
        if (rst) begin
            m_ov[i] = 0; m_gt[i] = 0; m_lt[i] = 0; m_eq[i] = 0; m_st[i] = 0;
            m_cnt[i] = 0; m_run[i] = 0; m_last[i] = 0;
        end else begin
            m_ov[i] = v;
            r = relation(a, b, s, w);
            if (c) m_cnt[i] = 0;
            else if (v && r == 3 && m_cnt[i] < (longint'(1) << cw) - 1) m_cnt[i]++;
            if (v) begin
                if (m_run[i] > 0 && r == m_last[i]) m_run[i]++;
                else m_run[i] = 1;
                m_last[i] = r;
                m_gt[i] = (r == 1);
                m_lt[i] = (r == 2);
                m_eq[i] = (r == 3);
                m_st[i] = (m_run[i] >= n);
            end
        end
    endtask

    task automatic compare(input int i, input string t, input bit ov, input bit gt,
                           input bit lt, input bit eq, input bit st, input longint cnt);
        check({t, "_out_valid"}, ov, m_ov[i]);
        check({t, "_gt"}, gt, m_gt[i]);
        check({t, "_lt"}, lt, m_lt[i]);
        check({t, "_eq"}, eq, m_eq[i]);
        check({t, "_stable"}, st, m_st[i]);
        check({t, "_eq_count"}, cnt, m_cnt[i]);
        if (ov) check({t, "_onehot"}, int'(gt) + int'(lt) + int'(eq), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, v8, a8, b8, s8, c8, 8, 4, 4);
        model_step(1, v32, a32, b32, s32, c32, 32, 4, 16);
        #1;
        compare(0, "w8", ov8, gt8, lt8, eq8, st8, cnt8);
        compare(1, "w32", ov32, gt32, lt32, eq32, st32, cnt32);
    endtask

    task automatic d8(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input bit s, input bit c);
        v8 = v; a8 = a; b8 = b; s8 = s; c8 = c;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("reset_out_valid", ov8, 0);
        check("reset_eq_count", cnt8, 0);
        check("reset_stable", st8, 0);
        rst = 1'b0;

        d8(1, 8'd150, 8'd100, 0, 0);
        check("u150_100_valid", ov8, 1);
        check("u150_100_gt", gt8, 1);
        check("u150_100_lt", lt8, 0);
        d8(1, 8'd60, 8'd180, 0, 0);
        check("u60_180_lt", lt8, 1);
        d8(1, 8'd200, 8'd200, 0, 0);
        check("u200_200_eq", eq8, 1);
        check("u200_200_count", cnt8, 1);
        d8(1, 8'hFF, 8'h01, 1, 0);
        check("sFF_01_lt", lt8, 1);
        d8(1, 8'hFF, 8'h01, 0, 0);
        check("uFF_01_gt", gt8, 1);
        d8(0, 8'h00, 8'h55, 0, 0);
        check("idle_valid_low", ov8, 0);
        check("idle_gt_held", gt8, 1);

        // Reset with a sample presented: it must be discarded.
        rst = 1'b1;
        d8(1, 8'd3, 8'd3, 0, 1);
        rst = 1'b0;
        check("rst_sample_dropped", cnt8, 0);

        d8(1, 8'd9, 8'd2, 0, 0);
        d8(1, 8'd9, 8'd2, 0, 0);
        d8(0, 8'd0, 8'd0, 0, 0);
        check("gap_not_stable", st8, 0);
        d8(1, 8'd50, 8'd7, 0, 0);
        check("third_gt_not_stable", st8, 0);
        d8(1, 8'd200, 8'd1, 0, 0);
        check("fourth_gt_stable", st8, 1);
        d8(1, 8'd1, 8'd2, 0, 0);
        check("lt_breaks_stable", st8, 0);
        check("lt_breaks_lt", lt8, 1);

        for (int k = 0; k < 5; k++) d8(1, 8'd3, 8'd3, 0, 0);
        check("five_eq_stable", st8, 1);
        check("five_eq_count", cnt8, 5);

        rst = 1'b1;
        d8(0, 8'd0, 8'd0, 0, 0);
        rst = 1'b0;
        check("midrun_rst_valid", ov8, 0);
        check("midrun_rst_eq", eq8, 0);
        check("midrun_rst_stable", st8, 0);
        check("midrun_rst_count", cnt8, 0);
        d8(1, 8'd3, 8'd3, 0, 0);
        check("after_rst_eq", eq8, 1);
        check("after_rst_stable", st8, 0);
        check("after_rst_count", cnt8, 1);

        // Mode toggles while the relation stays gt: the run keeps growing.
        for (int k = 0; k < 4; k++) d8(1, 8'd5, 8'd3, k[0], 0);
        check("mode_toggle_stable", st8, 1);

        d8(0, 8'd0, 8'd0, 0, 1);
        check("clr_alone", cnt8, 0);
        for (int k = 0; k < 17; k++) d8(1, 8'(k * 11), 8'(k * 11), k[0], 0);
        check("sat_at_15", cnt8, 15);
        d8(1, 8'd7, 8'd7, 0, 1);
        check("clr_wins", cnt8, 0);
        check("clr_wins_eq", eq8, 1);
        d8(0, 8'd0, 8'd0, 0, 0);
        check("clr_holds", cnt8, 0);

        // Random back-to-back traffic on the 32-bit instance.
        for (int k = 0; k < 300; k++) begin
            v32 = 1'b1;
            a32 = $urandom;
            b32 = ($urandom_range(0, 3) == 0) ? a32 : $urandom;
            if ($urandom_range(0, 5) == 0) b32 = a32 ^ 32'h8000_0000;
            s32 = $urandom_range(0, 1);
            c32 = ($urandom_range(0, 40) == 0);
            tick();
        end
        // Run of repeated gt samples to exercise stable in the wide instance.
        for (int k = 0; k < 6; k++) begin
            a32 = 32'h7000_0000 + k;
            b32 = 32'h0000_0010;
            s32 = k[0];
            c32 = 1'b0;
            tick();
        end
        check("w32_run_stable", st32, 1);
        v32 = 1'b0;
        tick();
        check("w32_idle_valid", ov32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
